alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests (operands plus 4-bit ALU control) from two requesters over valid/ready handshakes and grants one at a time. It registers the granted operands and drives them into the ALU, captures the result, and returns it to the owning requester with response backpressure. It sits between the execute-stage and address-generation requesters and the single ALU instance.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arb_grant.sv | 48 ++++
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: default datapath widths, the
// ALU control codes understood by the shared ALU, and the arbiter FSM state
// encoding.
// ----------------------------------------------------------------------------
package alu_pkg;

  // Default datapath widths
  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  // ALU control codes. Any code not listed makes the ALU produce 0.
  // ALU_NOP is what the arbiter drives while no operation is in flight.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage : alu_pkg

// File: rtl/alu_arb_grant.sv
// ----------------------------------------------------------------------------
// alu_arb_grant
// Two-way grant logic for the ALU arbiter. Produces a one-hot grant among the
// requesters whose valid is high; grant is all-zero when nobody is valid.
//
// Ports:
//   valid0_i    - requester 0 has a request pending
//   valid1_i    - requester 1 has a request pending
//   lastGrant_i - requester granted on the most recent accept (0 or 1)
//   grant_o     - one-hot grant, bit N set means requester N wins
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   - round-robin: on a tie, the requester not in lastGrant_i wins
//   undefined - fixed priority: requester 0 always wins a tie, lastGrant_i
//               is ignored
// ----------------------------------------------------------------------------
module alu_arb_grant (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       lastGrant_i,
  output logic [1:0] grant_o
);

  import alu_pkg::*;

`ifndef ALU_ARB_RR_EN
  // Fixed priority has no use for the grant history.
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant_i;
`endif

  // Tie resolution is the only place the two arbitration policies differ.
  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_RR_EN
      grant_o = lastGrant_i ? 2'b01 : 2'b10;
`else
      grant_o = 2'b01;
`endif
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule : alu_arb_grant

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Arbiter and sequencer for the single shared combinational ALU. Two
// requesters (execute stage and address generation) present operands plus an
// ALU control code over valid/ready. One request is granted at a time, its
// operands are registered and driven into the ALU for one cycle, the ALU
// result is captured and then returned to the owning requester, held until
// that requester takes it.
//
// Sequence: IDLE --accept--> EXEC --capture--> RESP --rsp handshake--> IDLE
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   Req0Valid/Req1Valid        - request present
//   Req0Ready/Req1Ready        - request accepted (IDLE and granted only)
//   Req0A/B, Req1A/B           - operands
//   Req0Ctrl/Req1Ctrl          - ALU control code, passed through unmodified
//   Rsp0Valid/Rsp1Valid        - result available for that requester
//   Rsp0Ready/Rsp1Ready        - requester takes the result
//   RspResult                  - captured result, shared by both responses
//   AluA/AluB/AluCtrl          - to the ALU; zeros and ALU_NOP outside EXEC
//   AluResult                  - from the ALU
//   Busy                       - high in any state other than IDLE
//
// Configuration macro: ALU_ARB_RR_EN (round-robin tie breaking when defined,
// fixed priority to requester 0 when undefined).
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [WIDTH-1:0]  Req0A,
  input  logic [WIDTH-1:0]  Req0B,
  input  logic [CTRL_W-1:0] Req0Ctrl,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [WIDTH-1:0]  Req1A,
  input  logic [WIDTH-1:0]  Req1B,
  input  logic [CTRL_W-1:0] Req1Ctrl,
  output logic              Rsp0Valid,
  input  logic              Rsp0Ready,
  output logic              Rsp1Valid,
  input  logic              Rsp1Ready,
  output logic [WIDTH-1:0]  RspResult,
  output logic [WIDTH-1:0]  AluA,
  output logic [WIDTH-1:0]  AluB,
  output logic [CTRL_W-1:0] AluCtrl,
  input  logic [WIDTH-1:0]  AluResult,
  output logic              Busy
);

  import alu_pkg::*;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(ALU_NOP);

  logic [1:0]        state_q,  state_d;
  logic              owner_q,  owner_d;
  logic [WIDTH-1:0]  opA_q,    opA_d;
  logic [WIDTH-1:0]  opB_q,    opB_d;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [1:0] grant;
  logic       lastGrant;
  logic       inIdle;
  logic       accept;
  logic       rspFire;

  assign inIdle = (state_q == ST_IDLE);

`ifdef ALU_ARB_RR_EN
  // Grant history for round-robin; starts at 1 so requester 0 wins the
  // first tie after reset.
  logic lastGrant_q, lastGrant_d;

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (accept) begin
      lastGrant_d = grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

  assign lastGrant = lastGrant_q;
`else
  assign lastGrant = 1'b1;
`endif

  alu_arb_grant u_grant (
    .valid0_i    (Req0Valid),
    .valid1_i    (Req1Valid),
    .lastGrant_i (lastGrant),
    .grant_o     (grant)
  );

  // Grant already implies the matching valid, so ready never asserts for an
  // absent request. Gating with rst_n keeps ready low while reset is held.
  assign Req0Ready = rst_n && inIdle && grant[0];
  assign Req1Ready = rst_n && inIdle && grant[1];
  assign accept    = inIdle && (grant != 2'b00);

  assign Rsp0Valid = (state_q == ST_RESP) && !owner_q;
  assign Rsp1Valid = (state_q == ST_RESP) &&  owner_q;
  assign rspFire   = (Rsp0Valid && Rsp0Ready) || (Rsp1Valid && Rsp1Ready);
  assign RspResult = result_q;
  assign Busy      = !inIdle;

  // The ALU only sees real operands during EXEC; otherwise it is parked on
  // zeros with the idle code so it produces 0.
  always_comb begin
    AluA    = '0;
    AluB    = '0;
    AluCtrl = CTRL_IDLE;
    if (state_q == ST_EXEC) begin
      AluA    = opA_q;
      AluB    = opB_q;
      AluCtrl = ctrl_q;
    end
  end

  // Next-state logic: latch the granted request on accept, capture the ALU
  // output at the end of EXEC, and hold everything in RESP until the owner
  // takes the result.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          opA_d   = grant[1] ? Req1A    : Req0A;
          opB_d   = grant[1] ? Req1B    : Req0B;
          ctrl_d  = grant[1] ? Req1Ctrl : Req0Ctrl;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = AluResult;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rspFire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
    end
  end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed testbench for alu_arbiter. A behavioural model of the shared ALU
// closes the loop on the Alu* ports. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// Tie-break expectations follow ALU_ARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [31:0] Req0A, Req0B, Req1A, Req1B;
  logic [3:0]  Req0Ctrl, Req1Ctrl;
  logic        Rsp0Valid, Rsp0Ready, Rsp1Valid, Rsp1Ready;
  logic [31:0] RspResult, AluA, AluB, AluResult;
  logic [3:0]  AluCtrl;
  logic        Busy;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Req0Valid (Req0Valid),
    .Req0Ready (Req0Ready),
    .Req0A     (Req0A),
    .Req0B     (Req0B),
    .Req0Ctrl  (Req0Ctrl),
    .Req1Valid (Req1Valid),
    .Req1Ready (Req1Ready),
    .Req1A     (Req1A),
    .Req1B     (Req1B),
    .Req1Ctrl  (Req1Ctrl),
    .Rsp0Valid (Rsp0Valid),
    .Rsp0Ready (Rsp0Ready),
    .Rsp1Valid (Rsp1Valid),
    .Rsp1Ready (Rsp1Ready),
    .RspResult (RspResult),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluCtrl   (AluCtrl),
    .AluResult (AluResult),
    .Busy      (Busy)
  );

  // Behavioural model of the shared combinational ALU
  always_comb begin
    AluResult = 32'd0;
    case (AluCtrl)
      4'b0000: AluResult = AluA + AluB;
      4'b0001: AluResult = AluA - AluB;
      4'b0010: AluResult = AluA & AluB;
      4'b0011: AluResult = AluA | AluB;
      4'b0100: AluResult = ($signed(AluA) < $signed(AluB)) ? 32'd1 : 32'd0;
      default: AluResult = 32'd0;
    endcase
  end

  task automatic idleInputs();
    Req0Valid = 1'b0; Req0A = '0; Req0B = '0; Req0Ctrl = '0;
    Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Req1Ctrl = '0;
    Rsp0Ready = 1'b0; Rsp1Ready = 1'b0;
  endtask

  task automatic applyStimulus(input int req, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] ctrl);
    if (req == 0) begin
      Req0Valid = 1'b1; Req0A = a; Req0B = b; Req0Ctrl = ctrl;
    end else begin
      Req1Valid = 1'b1; Req1A = a; Req1B = b; Req1Ctrl = ctrl;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkCount++;
    if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_ready actual=%b%b required=00", Req0Ready, Req1Ready);
    end
    checkCount++;
    if (Rsp0Valid !== 1'b0 || Rsp1Valid !== 1'b0 || Busy !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_flags rsp=%b%b busy=%b required=000", Rsp0Valid, Rsp1Valid, Busy);
    end
    checkCount++;
    if (RspResult !== 32'd0 || AluA !== 32'd0 || AluB !== 32'd0 || AluCtrl !== 4'hF) begin
      errorCount++;
      $display("[TB] FAIL reset_data result=%h a=%h b=%h ctrl=%h required 0/0/0/f",
               RspResult, AluA, AluB, AluCtrl);
    end
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    applyStimulus(0, 32'd7, 32'd5, ALU_ADD);
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    #1;
    checkCount++;
    if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL add_ready actual=%b%b required r0=1 r1=0", Req0Ready, Req1Ready);
    end
    @(negedge clk);
    Req0Valid = 1'b0;
    #1;
    checkCount++;
    if (AluCtrl !== 4'b0000 || AluA !== 32'd7 || AluB !== 32'd5 || Busy !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL add_exec ctrl=%h a=%0d b=%0d busy=%b required 0/7/5/1",
               AluCtrl, AluA, AluB, Busy);
    end
    checkCount++;
    if (Rsp0Valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL add_exec_rsp actual=%b required=0", Rsp0Valid);
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (Rsp0Valid !== 1'b1 || Rsp1Valid !== 1'b0 || RspResult !== 32'd12) begin
      errorCount++;
      $display("[TB] FAIL add_resp v0=%b v1=%b result=%0d required 1/0/12",
               Rsp0Valid, Rsp1Valid, RspResult);
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (Busy !== 1'b0 || Rsp0Valid !== 1'b0 || AluCtrl !== 4'hF) begin
      errorCount++;
      $display("[TB] FAIL add_idle busy=%b v0=%b ctrl=%h required 0/0/f", Busy, Rsp0Valid, AluCtrl);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int expGrant[3];
    bit sawReq1WithReq0;
    bit found;
    int waitCycles;
    int grantSeen;
    logic [31:0] expResult;
`ifdef ALU_ARB_RR_EN
    expGrant = '{0, 1, 0};
`else
    expGrant = '{0, 0, 0};
`endif
    sawReq1WithReq0 = 1'b0;
    applyStimulus(0, 32'd10, 32'd3, ALU_SUB);
    applyStimulus(1, 32'h0000_00F0, 32'h0000_003C, ALU_AND);
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    for (int op = 0; op < 3; op++) begin
      found = 1'b0;
      waitCycles = 0;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (Req1Ready && Req0Valid) sawReq1WithReq0 = 1'b1;
        if (Req0Ready || Req1Ready) begin
          found = 1'b1;
          break;
        end
        waitCycles++;
        @(negedge clk);
      end
      checkCount++;
      if (!found) begin
        errorCount++;
        $display("[TB] FAIL tie_accept_timeout op=%0d actual=no_ready required=ready", op);
      end
      grantSeen = Req1Ready ? 1 : 0;
      checkCount++;
      if (grantSeen != expGrant[op]) begin
        errorCount++;
        $display("[TB] FAIL tie_grant op=%0d actual=%0d required=%0d", op, grantSeen, expGrant[op]);
      end
      if (op > 0) begin
        // one IDLE cycle between RESP and the next accept: 3 cycles per op
        checkCount++;
        if (waitCycles != 1) begin
          errorCount++;
          $display("[TB] FAIL tie_throughput op=%0d actual_wait=%0d required=1", op, waitCycles);
        end
      end
      expResult = (expGrant[op] == 1) ? 32'h30 : 32'd7;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkCount++;
      if ((expGrant[op] == 1 ? Rsp1Valid : Rsp0Valid) !== 1'b1 ||
          (expGrant[op] == 1 ? Rsp0Valid : Rsp1Valid) !== 1'b0 ||
          RspResult !== expResult) begin
        errorCount++;
        $display("[TB] FAIL tie_resp op=%0d v0=%b v1=%b result=%h required owner=%0d result=%h",
                 op, Rsp0Valid, Rsp1Valid, RspResult, expGrant[op], expResult);
      end
      if (op == 2) begin
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
      end
    end
`ifndef ALU_ARB_RR_EN
    checkCount++;
    if (sawReq1WithReq0) begin
      errorCount++;
      $display("[TB] FAIL tie_fixed_req1_ready actual=asserted required=never");
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_undefined_code();
    applyStimulus(0, 32'd5, 32'd5, 4'b0111);
    Rsp0Ready = 1'b1;
    #1;
    checkCount++;
    if (Req0Ready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL undef_ready actual=%b required=1", Req0Ready);
    end
    @(negedge clk);
    Req0Valid = 1'b0;
    #1;
    checkCount++;
    if (AluCtrl !== 4'b0111 || AluA !== 32'd5) begin
      errorCount++;
      $display("[TB] FAIL undef_passthru ctrl=%b a=%0d required 0111/5", AluCtrl, AluA);
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (Rsp0Valid !== 1'b1 || RspResult !== 32'd0) begin
      errorCount++;
      $display("[TB] FAIL undef_resp v0=%b result=%h required 1/0", Rsp0Valid, RspResult);
    end
    checkCount++;
    if (AluCtrl !== 4'hF || AluA !== 32'd0 || AluB !== 32'd0) begin
      errorCount++;
      $display("[TB] FAIL undef_alu_idle ctrl=%h a=%h b=%h required f/0/0", AluCtrl, AluA, AluB);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    applyStimulus(0, 32'd3, 32'd9, ALU_SLT);
    Rsp0Ready = 1'b0;
    Rsp1Ready = 1'b1;
    #1;
    checkCount++;
    if (Req0Ready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL bp_ready actual=%b required=1", Req0Ready);
    end
    @(negedge clk);
    Req0Valid = 1'b0;
    applyStimulus(1, 32'd1, 32'd2, ALU_OR);
    #1;
    checkCount++;
    if (Req1Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL bp_exec_req1 actual=%b required=0", Req1Ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkCount++;
      if (Rsp0Valid !== 1'b1 || RspResult !== 32'd1) begin
        errorCount++;
        $display("[TB] FAIL bp_hold cycle=%0d v0=%b result=%h required 1/1", c, Rsp0Valid, RspResult);
      end
      checkCount++;
      if (Req1Ready !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL bp_req1_ready cycle=%0d actual=%b required=0", c, Req1Ready);
      end
    end
    @(negedge clk);
    Rsp0Ready = 1'b1;
    #1;
    checkCount++;
    if (Rsp0Valid !== 1'b1 || Req1Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL bp_release v0=%b r1=%b required 1/0", Rsp0Valid, Req1Ready);
    end
    @(negedge clk);
    #1;
    checkCount++;
    if (Busy !== 1'b0 || Req1Ready !== 1'b1 || Rsp0Valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL bp_idle busy=%b r1=%b v0=%b required 0/1/0", Busy, Req1Ready, Rsp0Valid);
    end
    @(negedge clk);
    Req1Valid = 1'b0;
    @(negedge clk);
    #1;
    checkCount++;
    if (Rsp1Valid !== 1'b1 || Rsp0Valid !== 1'b0 || RspResult !== 32'd3) begin
      errorCount++;
      $display("[TB] FAIL bp_req1_resp v1=%b v0=%b result=%0d required 1/0/3",
               Rsp1Valid, Rsp0Valid, RspResult);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    applyStimulus(0, 32'd1, 32'd2, ALU_ADD);
    Rsp0Ready = 1'b0;
    Rsp1Ready = 1'b0;
    #1;
    checkCount++;
    if (Req0Ready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL rst_exec_accept actual=%b required=1", Req0Ready);
    end
    @(negedge clk);
    Req1Valid = 1'b1;
    #1;
    checkCount++;
    if (Busy !== 1'b1 || AluCtrl !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL rst_exec_state busy=%b ctrl=%h required 1/0", Busy, AluCtrl);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (Busy !== 1'b0 || Req0Ready !== 1'b0 || Req1Ready !== 1'b0 ||
        Rsp0Valid !== 1'b0 || Rsp1Valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL rst_exec_flags busy=%b r=%b%b v=%b%b required all 0",
               Busy, Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid);
    end
    checkCount++;
    if (RspResult !== 32'd0 || AluA !== 32'd0 || AluB !== 32'd0 || AluCtrl !== 4'hF) begin
      errorCount++;
      $display("[TB] FAIL rst_exec_data result=%h a=%h b=%h ctrl=%h required 0/0/0/f",
               RspResult, AluA, AluB, AluCtrl);
    end
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    Rsp0Ready = 1'b1;
    Rsp1Ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkCount++;
      if (Rsp0Valid !== 1'b0 || Rsp1Valid !== 1'b0 || Busy !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL rst_exec_no_rsp cycle=%0d v=%b%b busy=%b required 0/0/0",
                 c, Rsp0Valid, Rsp1Valid, Busy);
      end
    end
    @(negedge clk);
    applyStimulus(0, 32'd20, 32'd22, ALU_ADD);
    applyStimulus(1, 32'h0000_00F0, 32'h0000_003C, ALU_AND);
    #1;
    checkCount++;
    if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL rst_first_tie r=%b%b required r0=1 r1=0", Req0Ready, Req1Ready);
    end
    @(negedge clk);
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    @(negedge clk);
    #1;
    checkCount++;
    if (Rsp0Valid !== 1'b1 || RspResult !== 32'd42) begin
      errorCount++;
      $display("[TB] FAIL rst_new_resp v0=%b result=%0d required 1/42", Rsp0Valid, RspResult);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_tie();
    test_undefined_code();
    test_backpressure();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Guards against a stuck simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_alu_arbiter
